// File: rtl/led_matrix_scan_driver.sv
// led_matrix_scan_driver
// Column-scan driver for an 8-column LED matrix. Follows the external scan
// counter's index/loopEnd, drives a registered one-hot column select and the
// selected column's row pattern, and keeps a double-buffered frame store so
// a frame swap only ever happens at a scan-loop boundary (no tearing).
//
// There is no valid/ready handshake here: wr_en and commit are plain strobes
// sampled on every rising edge, and they are never back-pressured.
//
// The only control state is the pending-swap bit, which is exposed directly
// on swap_pending for observation.

module led_matrix_scan_driver #(
  parameter int ROWS           = 7,
  parameter bit COL_ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            scan_en,
  input  logic [2:0]      index,
  input  logic            loopEnd,
  input  logic            wr_en,
  input  logic [2:0]      wr_addr,
  input  logic [ROWS-1:0] wr_data,
  input  logic            commit,
  output logic [7:0]      col_sel,
  output logic [ROWS-1:0] row_data,
  output logic            swap_pending,
  output logic            frame_done
);

  // Column-select encodings in the configured polarity.
  localparam logic [7:0] COL_OFF = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [ROWS-1:0] r_shadow [8];
  logic [ROWS-1:0] r_active [8];
  logic            r_pending;
  logic            r_frame_done;
  logic [7:0]      r_col_sel;
  logic [ROWS-1:0] r_row_data;

  logic [7:0]      w_onehot;
  logic [7:0]      w_col_on;
  logic            w_swap;

  // Decode the incoming index into the selected column pattern.
  always_comb begin
    w_onehot = 8'b0000_0001 << index;
    w_col_on = COL_ACTIVE_LOW ? ~w_onehot : w_onehot;
  end

  // A swap happens at the last column of a loop when a request is waiting or
  // arrives in that same cycle; it is independent of scan_en so commits still
  // complete while the display is blanked.
  assign w_swap = loopEnd & (r_pending | commit);

  // Shadow buffer: host writes land here in any cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) r_shadow[i] <= '0;
    end else if (wr_en) begin
      r_shadow[wr_addr] <= wr_data;
    end
  end

  // Active buffer: copied wholesale from shadow on a swap. Non-blocking
  // semantics mean a write in the swap cycle is not part of the copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) r_active[i] <= '0;
    end else if (w_swap) begin
      for (int i = 0; i < 8; i++) r_active[i] <= r_shadow[i];
    end
  end

  // Pending-swap flag and the one-cycle frame_done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_swap;
      if (w_swap) begin
        r_pending <= 1'b0;
      end else if (commit) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Display path: the row read sees the active buffer before any swap on the
  // same edge, so column 7 always comes from the outgoing frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col_sel  <= COL_OFF;
      r_row_data <= '0;
    end else if (scan_en) begin
      r_col_sel  <= w_col_on;
      r_row_data <= r_active[index];
    end else begin
      r_col_sel  <= COL_OFF;
      r_row_data <= '0;
    end
  end

  assign col_sel      = r_col_sel;
  assign row_data     = r_row_data;
  assign swap_pending = r_pending;
  assign frame_done   = r_frame_done;

endmodule
